// File: rtl/panel_loader.sv
// Front-panel program loader: debounced keys drive an address-set / write-and-advance
// sequence into the memory write port while the CPU sits in its load state.
module panel_loader #(
    parameter int DEB_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [7:0] SW,
    input  logic       key_addr_n,
    input  logic       key_data_n,
    input  logic       mem_ack,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    output logic       busy,
    output logic [7:0] entry_cnt,
    output logic       err,
    output logic [1:0] dbg_state_o
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [1:0] key_n;
    logic [1:0] press;

    assign key_n = {key_data_n, key_addr_n};

    // Bit 0 is the address key, bit 1 the data key; both paths are identical
    // so simultaneous falls produce presses in the same cycle.
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic          sync1_q;
        logic          sync2_q;
        logic          deb_q;
        logic          deb_dly_q;
        logic          press_q;
        logic [DW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                deb_q     <= 1'b1;
                deb_dly_q <= 1'b1;
                press_q   <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= key_n[g];
                sync2_q   <= sync1_q;
                deb_dly_q <= deb_q;
                press_q   <= deb_dly_q & ~deb_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DEB_LAST) begin
                    deb_q <= ~deb_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[g] = press_q;
    end

    state_t        state_q;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    cnt_q;
    logic          we_q;
    logic          err_q;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        if (press[0]) begin
                            addr_q <= SW;
                            err_q  <= press[1];
                        end else if (press[1]) begin
                            data_q  <= SW;
                            we_q    <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (|press) begin
                        err_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        we_q    <= 1'b0;
                        state_q <= DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    if (|press) begin
                        err_q <= 1'b1;
                    end
                    addr_q  <= addr_q + 8'h01;
                    cnt_q   <= cnt_q + 8'h01;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign mem_we      = we_q;
    assign entry_cnt   = cnt_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
